// File: rtl/color_mapper_pipe_if.sv
// Pixel stream bundle for color_mapper_pipe: iteration samples in, RGB pixels out.
// The mapper connects to the slave modport; a producer/consumer pair uses master.
interface color_mapper_pipe_if #(
    parameter int unsigned ITER_W  = 32,
    parameter int unsigned COLOR_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [ITER_W-1:0]  iter_in;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               out_last;

    modport slave (
        input  in_valid, iter_in, in_last, out_ready,
        output in_ready, out_valid, r, g, b, out_last
    );

    modport master (
        output in_valid, iter_in, in_last, out_ready,
        input  in_ready, out_valid, r, g, b, out_last
    );
endinterface

// File: rtl/color_mapper_pipe.sv
// Two-stage valid/ready colouriser: iteration count -> RGB via ramp, grayscale
// or a writable palette with a colour-cycling offset.
module color_mapper_pipe #(
    parameter int unsigned ITER_W  = 32,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned PAL_AW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    color_mapper_pipe_if.slave     strm,
    input  logic [ITER_W-1:0]      max_iter,
    input  logic [1:0]             mode,
    input  logic [PAL_AW-1:0]      color_offset,
    input  logic [3*COLOR_W-1:0]   inside_rgb,
    input  logic                   pal_we,
    input  logic [PAL_AW-1:0]      pal_addr,
    input  logic [3*COLOR_W-1:0]   pal_wdata
);
    localparam int unsigned PAL_W = 3 * COLOR_W;
    localparam int unsigned DEPTH = 1 << PAL_AW;
    localparam logic [COLOR_W-1:0] MAXC = '1;

    typedef enum logic [1:0] {
        MODE_RAMP = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_PAL  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Stage 1
    logic               v1_q;
    logic               last1_q;
    mode_e              mode1_q;
    logic [PAL_W-1:0]   inside1_q;
    logic               int1_q;
    logic [2:0]         seg1_q;
    logic [COLOR_W-1:0] f1_q;
    logic [PAL_W-1:0]   pal_rd_q;

    // Stage 2 / outputs
    logic               ov_q;
    logic               olast_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic [COLOR_W-1:0] r_d, g_d, b_d;

    logic               en;
    logic [ITER_W-1:0]  seg_full;
    logic [2:0]         seg_sat;
    logic [PAL_AW-1:0]  pal_idx;

    logic [PAL_W-1:0]   pal_mem [DEPTH];

    assign en            = !ov_q || strm.out_ready;
    assign strm.in_ready = !rst && en;

    assign seg_full = strm.iter_in >> COLOR_W;
    assign seg_sat  = (seg_full >= ITER_W'(4)) ? 3'd4 : seg_full[2:0];
    assign pal_idx  = strm.iter_in[PAL_AW-1:0] + color_offset;

    // Palette storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (pal_we) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            pal_rd_q <= pal_mem[pal_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            mode1_q   <= MODE_RAMP;
            inside1_q <= '0;
            int1_q    <= 1'b0;
            seg1_q    <= '0;
            f1_q      <= '0;
        end else if (en) begin
            v1_q      <= strm.in_valid;
            last1_q   <= strm.in_last;
            mode1_q   <= mode_e'(mode);
            inside1_q <= inside_rgb;
            int1_q    <= (strm.iter_in >= max_iter);
            seg1_q    <= seg_sat;
            f1_q      <= strm.iter_in[COLOR_W-1:0];
        end
    end

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (int1_q) begin
            {r_d, g_d, b_d} = inside1_q;
        end else begin
            unique case (mode1_q)
                MODE_RAMP: begin
                    unique case (seg1_q)
                        3'd0: r_d = f1_q;
                        3'd1: begin
                            r_d = MAXC;
                            g_d = f1_q;
                        end
                        3'd2: begin
                            r_d = MAXC - f1_q;
                            g_d = MAXC;
                            b_d = f1_q;
                        end
                        3'd3: begin
                            g_d = MAXC - f1_q;
                            b_d = MAXC;
                        end
                        default: b_d = MAXC;
                    endcase
                end
                MODE_GRAY: begin
                    r_d = f1_q;
                    g_d = f1_q;
                    b_d = f1_q;
                end
                MODE_PAL: {r_d, g_d, b_d} = pal_rd_q;
                MODE_RSVD: begin
                    r_d = '0;
                    g_d = '0;
                    b_d = '0;
                end
                default: begin
                    r_d = '0;
                    g_d = '0;
                    b_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q    <= 1'b0;
            olast_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else if (en) begin
            ov_q    <= v1_q;
            olast_q <= last1_q;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign strm.out_valid = ov_q;
    assign strm.out_last  = olast_q;
    assign strm.r         = r_q;
    assign strm.g         = g_q;
    assign strm.b         = b_q;
endmodule

// File: tb/tb_color_mapper_pipe.sv
// Scoreboard bench for color_mapper_pipe: directed plan cases plus randomized
// traffic checked against a behavioural colour model.
module tb_color_mapper_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] max_iter_s = 32'd2000;
    logic [1:0]  mode_s = 2'd0;
    logic [7:0]  offset_s = 8'd0;
    logic [23:0] inside_s = 24'h0;
    logic        pal_we_s = 1'b0;
    logic [7:0]  pal_addr_s = 8'd0;
    logic [23:0] pal_wdata_s = 24'h0;

    color_mapper_pipe_if #(.ITER_W(32), .COLOR_W(8)) bus ();

    color_mapper_pipe #(.ITER_W(32), .COLOR_W(8), .PAL_AW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .strm         (bus),
        .max_iter     (max_iter_s),
        .mode         (mode_s),
        .color_offset (offset_s),
        .inside_rgb   (inside_s),
        .pal_we       (pal_we_s),
        .pal_addr     (pal_addr_s),
        .pal_wdata    (pal_wdata_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic        last;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          rand_bp = 0;
    bit          prev_stalled = 0;
    logic [25:0] held;
    logic [23:0] pal_m [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pal_we_s) pal_m[pal_addr_s] <= pal_wdata_s;
    end

    always @(negedge clk) begin
        if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model(input logic [31:0] it, input logic [31:0] mi,
                                          input logic [1:0] md, input logic [7:0] off,
                                          input logic [23:0] ins);
        int unsigned seg;
        logic [7:0]  f;
        if (it >= mi) return ins;
        seg = it / 256;
        f   = 8'(it % 256);
        case (md)
            2'd0: begin
                if (seg == 0) return {f, 8'h00, 8'h00};
                if (seg == 1) return {8'hFF, f, 8'h00};
                if (seg == 2) return {8'hFF - f, 8'hFF, f};
                if (seg == 3) return {8'h00, 8'hFF - f, 8'hFF};
                return {8'h00, 8'h00, 8'hFF};
            end
            2'd1: return {f, f, f};
            2'd2: return pal_m[(it + 32'(off)) % 256];
            default: return 24'h0;
        endcase
    endfunction

    // Monitor: checks every transferred pixel and stability of stalled outputs.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (prev_stalled)
                chk("stall_hold", {bus.out_valid, bus.out_last, bus.r, bus.g, bus.b}, held);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %0h expected none", {bus.r, bus.g, bus.b});
                end else begin
                    e = sb.pop_front();
                    chk("pixel", {bus.out_last, bus.r, bus.g, bus.b}, {e.last, e.rgb});
                    if (e.lat) chk("latency", cyc - e.acc, 2);
                end
            end
            prev_stalled = bus.out_valid && !bus.out_ready;
            held = {bus.out_valid, bus.out_last, bus.r, bus.g, bus.b};
        end
    end

    always @(posedge rst) prev_stalled = 0;

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input logic [31:0] it, input logic lst, input logic [23:0] ex, input bit lat);
        bus.iter_in  = it;
        bus.in_last  = lst;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            #1;
            if (bus.in_ready) begin
                sb.push_back('{ex, lst, cyc, lat});
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got no in_ready expected accept of iter %0d", it);
        bus.in_valid = 1'b0;
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
        pal_we_s    = 1'b1;
        pal_addr_s  = a;
        pal_wdata_s = d;
        @(negedge clk);
        pal_we_s    = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] it, mi;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.iter_in   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_outputs", {bus.out_valid, bus.out_last, bus.r, bus.g, bus.b}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", bus.in_ready, 1);
        @(negedge clk);

        for (int a = 0; a < 256; a++) pal_write(8'(a), 24'($urandom));

        // Ramp with latency
        max_iter_s = 2000;
        mode_s     = 2'd0;
        send(100,  0, 24'h640000, 1);
        send(300,  0, 24'hFF2C00, 1);
        send(600,  0, 24'hA7FF58, 1);
        send(800,  0, 24'h00DFFF, 1);
        send(1100, 0, 24'h0000FF, 1);
        drain();

        // Interior override
        max_iter_s = 1000;
        inside_s   = 24'h102030;
        for (int m = 0; m < 3; m++) begin
            mode_s = 2'(m);
            send(1000, 0, 24'h102030, 0);
        end
        mode_s = 2'd3;
        send(5, 0, 24'h000000, 0);
        drain();

        // Palette with offset and read-during-write
        max_iter_s = 2000;
        pal_write(8'd5, 24'h123456);
        offset_s = 8'd3;
        mode_s   = 2'd2;
        send(2, 0, 24'h123456, 0);
        pal_we_s = 1'b1; pal_addr_s = 8'd5; pal_wdata_s = 24'hABCDEF;
        send(2, 0, 24'h123456, 0);
        pal_we_s = 1'b0;
        send(2, 0, 24'hABCDEF, 0);
        drain();

        // Backpressure: out_ready low for cycles 3..7
        mode_s = 2'd1;
        fork
            for (int i = 1; i <= 6; i++) send(32'(i), (i == 6), {3{8'(i)}}, 0);
            begin
                repeat (2) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Sideband sampled only at accept
        mode_s = 2'd0;
        send(300, 0, 24'hFF2C00, 0);
        mode_s = 2'd1;
        drain();

        // Reset with two pixels in flight
        bus.out_ready = 1'b0;
        send(10, 0, 24'h0A0A0A, 0);
        send(11, 0, 24'h0B0B0B, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {bus.out_valid, bus.out_last, bus.r, bus.g, bus.b}, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("in_ready_after_midrst", bus.in_ready, 1);
        @(negedge clk);
        offset_s = 8'd0;
        mode_s   = 2'd2;
        send(7, 0, pal_m[7], 0);
        send(5, 0, 24'hABCDEF, 0);
        drain();

        // Randomized traffic under random backpressure
        rand_bp = 1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) pal_write(8'($urandom), 24'($urandom));
            mi = $urandom_range(0, 1600);
            case ($urandom_range(0, 3))
                0: it = $urandom;
                1: it = mi + $urandom_range(0, 2) - 1;
                default: it = $urandom_range(0, 1500);
            endcase
            max_iter_s = mi;
            mode_s     = 2'($urandom);
            offset_s   = 8'($urandom);
            inside_s   = 24'($urandom);
            send(it, 1'($urandom), model(it, mi, mode_s, offset_s, inside_s), 0);
        end
        rand_bp = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/color_mapper_pipe.md
# color_mapper_pipe

Parametrised, streaming successor to the fixed 8-bit iteration colouriser. It sits between the Mandelbrot iteration engine and the pixel/VGA output path. Each accepted iteration count becomes one RGB pixel through a 2-stage valid/ready pipeline. It selects one of three colouring modes at runtime: legacy ramp, grayscale, or a writable palette with colour-cycling offset.

## Interface
Parameters:
- ITER_W, 32, width of iteration count and max_iter
- COLOR_W, 8, bits per colour channel; ramp segment length L = 2^COLOR_W, MAXC = L-1
- PAL_AW, 8, palette address width; palette depth = 2^PAL_AW entries of 3*COLOR_W bits

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  iteration sample valid
- in_ready  out  1  block can accept a sample this cycle
- iter_in  in  ITER_W  iteration count
- in_last  in  1  sideband (end of line/frame), passed through aligned with the pixel
- max_iter  in  ITER_W  interior threshold, sampled with each accepted pixel
- mode  in  2  0 = ramp, 1 = grayscale, 2 = palette, 3 = reserved; sampled per pixel
- color_offset  in  PAL_AW  palette index offset for colour cycling; sampled per pixel
- inside_rgb  in  3*COLOR_W  colour for interior pixels {r,g,b}; sampled per pixel
- pal_we  in  1  palette write strobe
- pal_addr  in  PAL_AW  palette write address
- pal_wdata  in  3*COLOR_W  palette write data {r,g,b}
- out_valid  out  1  pixel valid
- out_ready  in  1  downstream accepts pixel
- r, g, b  out  COLOR_W each  pixel colour
- out_last  out  1  delayed in_last

## Operation
- Pipeline enable: en = !out_valid || out_ready. When rst is low, in_ready = en. While rst is high, in_ready = 0. Accept happens when in_valid && in_ready.
- Stage 1 registers the following on accept, and advances only when en is high:
  - valid bit, last bit, mode, inside_rgb
  - interior flag = (iter_in >= max_iter), unsigned compare
  - ramp segment seg = iter_in >> COLOR_W, saturated to 4 in a 3-bit field
  - fraction f = iter_in[COLOR_W-1:0]
  - palette read at index (iter_in[PAL_AW-1:0] + color_offset) mod 2^PAL_AW. Synchronous read, read enable = en.
- Stage 2 composes the colour into the r/g/b registers when en is high. out_valid takes the stage-1 valid bit.
- Colour rules. Interior overrides every mode, including mode 3.
  - Interior: {r,g,b} = inside_rgb.
  - mode 0:
    - seg0 → (f, 0, 0)
    - seg1 → (MAXC, f, 0)
    - seg2 → (MAXC-f, MAXC, f)
    - seg3 → (0, MAXC-f, MAXC)
    - seg ≥ 4 → (0, 0, MAXC)
    - All subtractions are COLOR_W-bit and cannot underflow.
  - mode 1: (f, f, f).
  - mode 2: palette entry; bits [3*COLOR_W-1 -: COLOR_W] = r, then g, then b.
  - mode 3: (0, 0, 0).
- Palette:
  - Written whenever pal_we = 1, independent of stall and stream state.
  - A write and read of the same address in the same cycle returns the old data.
  - Contents are not reset and are undefined until written.
- No pixel is dropped, duplicated or reordered under any out_ready pattern.

## Timing
- Latency is 2 cycles from accept to out_valid when out_ready is held high. Throughput is 1 pixel per cycle.
- While stalled (out_valid && !out_ready): r, g, b, out_last and out_valid are held stable, and no stage advances.
- Sideband inputs (max_iter, mode, color_offset, inside_rgb) matter only in the accept cycle. Changing them later has no effect on in-flight pixels.
- Reset values:
  - out_valid = 0; r = g = b = 0; out_last = 0
  - both stage valid bits = 0
  - in_ready = 0 while rst is high, 1 in the first cycle after release
- Reset asserted mid-stream discards all in-flight pixels immediately (asynchronously). The palette is unaffected.

## Test plan
- Ramp, COLOR_W = 8, max_iter = 2000, mode 0. Stimulus iter = 100, 300, 600, 800, 1100. Required outputs: (100,0,0), (255,44,0), (167,255,88), (0,223,255), (0,0,255). Each arrives 2 cycles after its accept.
- Interior: iter = 1000, max_iter = 1000, inside_rgb = 0x102030. Output is (0x10,0x20,0x30) in modes 0, 1 and 2. Mode 3 with iter = 5 gives (0,0,0).
- Palette: write addr 5 = 0x123456, color_offset = 3, mode 2, iter = 2 → (0x12,0x34,0x56). Then write addr 5 = 0xABCDEF in the same cycle as a read of index 5: that read returns 0x123456 and the next one returns 0xABCDEF.
- Backpressure: stream 6 pixels (iter 1 to 6, mode 1, last on the 6th) with out_ready = 0 for cycles 3–7. Outputs must be gray 1..6 in order, each held stable while stalled, and out_last set only on gray 6.
- Mid-stream sampling: change mode from 0 to 1 one cycle after accepting iter = 300. The pixel still shows (255,44,0).
- Reset: assert rst with 2 pixels in flight. Then out_valid = 0 and r = g = b = 0 immediately, and in_ready = 0. After release, a previously written palette entry reads back unchanged.
